mem_initiator: RTL and testbench

Bus-master end of the `memInt` memory protocol. It accepts burst read/write commands on a valid/ready command port and streams write data in. It drives the `read`/`write`/`addr`/`data_in` controls of the 32×8 synchronous-write, combinational-read memory, and returns read data on a back-pressurable stream. It sits between testbench or processor-side logic and the `mem` responder, and is the only agent driving that interface.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_rd_skid.sv | 32 +++
 rtl/mem_initiator.sv | 112 +++++++++++
 tb/tb_mem_initiator.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default widths for the memInt initiator slice.
package mem_pkg;

    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DATA_W = 8;
    localparam int MEM_LEN_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } mem_init_state_e;

endpackage

// File: rtl/mem_rd_skid.sv
// Single-entry read-data output register with valid/ready handshake and a last-beat flag.
module mem_rd_skid #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              rdata_ready,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last
);

    // A load always wins; it is only issued when the entry is free or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_valid <= 1'b0;
            rdata       <= '0;
            rdata_last  <= 1'b0;
        end else if (load) begin
            rdata_valid <= 1'b1;
            rdata       <= load_data;
            rdata_last  <= load_last;
        end else if (rdata_valid && rdata_ready) begin
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_initiator.sv
// Bus-master end of the memInt protocol: burst commands in, memory controls and read stream out.
// Optional beat counters wr_beats/rd_beats are built when MEM_INITIATOR_STATS_EN is defined.
module mem_initiator
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int LEN_W  = MEM_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_done,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
`ifdef MEM_INITIATOR_STATS_EN
    output logic [15:0]       wr_beats,
    output logic [15:0]       rd_beats,
`endif
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    mem_init_state_e   state;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat;
    logic              wr_issue;
    logic              rd_issue;
    logic              issue;
    logic              last_beat;

    assign wr_issue  = (state == WR) && wdata_valid;
    assign rd_issue  = (state == RD) && (!rdata_valid || rdata_ready);
    assign issue     = wr_issue || rd_issue;
    assign last_beat = (beat == len_q);

    assign cmd_ready   = (state == IDLE);
    assign wdata_ready = (state == WR);
    assign cmd_done    = issue && last_beat;

    // Memory controls are driven only in issuing cycles so the bus idles at zero.
    assign mem_write   = wr_issue;
    assign mem_read    = rd_issue;
    assign mem_addr    = issue ? ADDR_W'(base + ADDR_W'(beat)) : '0;
    assign mem_data_in = wr_issue ? wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            base  <= '0;
            len_q <= '0;
            beat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        base  <= cmd_addr;
                        len_q <= cmd_len;
                        beat  <= '0;
                        state <= cmd_write ? WR : RD;
                    end
                end
                WR, RD: begin
                    if (issue) begin
                        if (last_beat) state <= IDLE;
                        else           beat  <= beat + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_rd_skid #(.DATA_W(DATA_W)) u_rd_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (rd_issue),
        .load_data   (mem_data_out),
        .load_last   (last_beat),
        .rdata_ready (rdata_ready),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .rdata_last  (rdata_last)
    );

`ifdef MEM_INITIATOR_STATS_EN
    // Saturating issued-beat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_beats <= '0;
            rd_beats <= '0;
        end else begin
            if (wr_issue && (wr_beats != 16'hFFFF)) wr_beats <= wr_beats + 16'd1;
            if (rd_issue && (rd_beats != 16'hFFFF)) rd_beats <= rd_beats + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_initiator.sv
// Directed, table-driven bench for mem_initiator with a behavioural 32x8 memory model.
module tb_mem_initiator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [4:0] cmd_addr = '0;
    logic [2:0] cmd_len = '0;
    logic       cmd_done;
    logic       wdata_valid = 1'b0;
    logic       wdata_ready;
    logic [7:0] wdata = '0;
    logic       rdata_valid;
    logic       rdata_ready = 1'b0;
    logic [7:0] rdata;
    logic       rdata_last;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] mem_addr;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;
`ifdef MEM_INITIATOR_STATS_EN
    logic [15:0] wr_beats;
    logic [15:0] rd_beats;
`endif

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [2:0]  len;
        logic [63:0] data;
        logic        gapped;
        logic [3:0]  readyPat;
    } vec_t;

    vec_t       vecs [8];
    int         nVec = 0;
    int         nMiss = 0;
    logic [7:0] memModel [32];

    mem_initiator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_done     (cmd_done),
        .wdata_valid  (wdata_valid),
        .wdata_ready  (wdata_ready),
        .wdata        (wdata),
        .rdata_valid  (rdata_valid),
        .rdata_ready  (rdata_ready),
        .rdata        (rdata),
        .rdata_last   (rdata_last),
`ifdef MEM_INITIATOR_STATS_EN
        .wr_beats     (wr_beats),
        .rd_beats     (rd_beats),
`endif
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Synchronous-write, combinational-read responder.
    always @(posedge clk) begin
        if (mem_write) memModel[mem_addr] <= mem_data_in;
    end
    assign mem_data_out = memModel[mem_addr];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sendCmd(input logic wr, input logic [4:0] addr, input logic [2:0] len);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        checkOutput("cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic doWrite(input logic [4:0] addr, input logic [2:0] len,
                           input logic [63:0] data, input logic gapped);
        sendCmd(1'b1, addr, len);
        for (int b = 0; b <= int'(len); b++) begin
            if (gapped && b > 0) begin
                wdata_valid = 1'b0;
                wdata = 8'hEE;
                @(negedge clk);
                checkOutput("wr_gap_write", 32'(mem_write), 32'd0);
                checkOutput("wr_gap_data", 32'(mem_data_in), 32'd0);
                @(posedge clk);
                #1;
            end
            wdata_valid = 1'b1;
            wdata = data[8*b +: 8];
            @(negedge clk);
            checkOutput("wr_write", 32'(mem_write), 32'd1);
            checkOutput("wr_noread", 32'(mem_read), 32'd0);
            checkOutput("wr_addr", 32'(mem_addr), 32'(5'(addr + 5'(b))));
            checkOutput("wr_data", 32'(mem_data_in), 32'(data[8*b +: 8]));
            checkOutput("wr_done", 32'(cmd_done), 32'(b == int'(len)));
            @(posedge clk);
            #1;
        end
        wdata_valid = 1'b0;
        wdata = '0;
    endtask

    task automatic doRead(input logic [4:0] addr, input logic [2:0] len,
                          input logic [63:0] data, input logic [3:0] pat);
        int   issued = 0;
        int   consumed = 0;
        int   cyc = 0;
        logic pend = 1'b0;
        logic expIssue;
        sendCmd(1'b0, addr, len);
        while (consumed <= int'(len) && cyc < 200) begin
            rdata_ready = pat[cyc % 4];
            @(negedge clk);
            expIssue = (issued <= int'(len)) && (!pend || rdata_ready);
            checkOutput("rd_read", 32'(mem_read), 32'(expIssue));
            checkOutput("rd_nowrite", 32'(mem_write), 32'd0);
            if (expIssue) begin
                checkOutput("rd_addr", 32'(mem_addr), 32'(5'(addr + 5'(issued))));
                checkOutput("rd_done", 32'(cmd_done), 32'(issued == int'(len)));
            end else begin
                checkOutput("rd_idle_addr", 32'(mem_addr), 32'd0);
            end
            checkOutput("rd_valid", 32'(rdata_valid), 32'(pend));
            if (pend) begin
                checkOutput("rd_data", 32'(rdata), 32'(data[8*consumed +: 8]));
                checkOutput("rd_last", 32'(rdata_last), 32'(consumed == int'(len)));
                if (rdata_ready) consumed++;
            end
            @(posedge clk);
            #1;
            if (expIssue) begin
                pend = 1'b1;
                issued++;
            end else if (pend && rdata_ready) begin
                pend = 1'b0;
            end
            cyc++;
        end
        if (consumed <= int'(len)) checkOutput("rd_timeout", 32'd0, 32'd1);
        rdata_ready = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.wr) doWrite(v.addr, v.len, v.data, v.gapped);
        else      doRead(v.addr, v.len, v.data, v.readyPat);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd4,  3'd3, 64'h00000000_A4A3A2A1, 1'b0, 4'b1111};
        vecs[1] = '{1'b0, 5'd4,  3'd3, 64'h00000000_A4A3A2A1, 1'b0, 4'b1111};
        vecs[2] = '{1'b1, 5'd30, 3'd2, 64'h00000000_00332211, 1'b0, 4'b1111};
        vecs[3] = '{1'b0, 5'd30, 3'd2, 64'h00000000_00332211, 1'b0, 4'b1111};
        vecs[4] = '{1'b1, 5'd8,  3'd7, 64'h08070605_04030201, 1'b0, 4'b1111};
        vecs[5] = '{1'b0, 5'd8,  3'd7, 64'h08070605_04030201, 1'b0, 4'b1001};
        vecs[6] = '{1'b1, 5'd16, 3'd3, 64'h00000000_C4C3C2C1, 1'b1, 4'b1111};
        vecs[7] = '{1'b0, 5'd16, 3'd3, 64'h00000000_C4C3C2C1, 1'b0, 4'b1111};
        for (int i = 0; i < 32; i++) memModel[i] = 8'h00;

        #2;
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_cmd_done", 32'(cmd_done), 32'd0);
        checkOutput("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        checkOutput("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        checkOutput("rst_rdata", 32'(rdata), 32'd0);
        checkOutput("rst_rdata_last", 32'(rdata_last), 32'd0);
        checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
        checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_data_in", 32'(mem_data_in), 32'd0);
`ifdef MEM_INITIATOR_STATS_EN
        checkOutput("rst_wr_beats", 32'(wr_beats), 32'd0);
        checkOutput("rst_rd_beats", 32'(rd_beats), 32'd0);
`endif
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'd1);
            checkOutput("idle_mem_read", 32'(mem_read), 32'd0);
            checkOutput("idle_mem_write", 32'(mem_write), 32'd0);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Reset asserted while beat 2 of a 6-beat write is on the bus.
        sendCmd(1'b1, 5'd0, 3'd5);
        for (int b = 0; b < 2; b++) begin
            wdata_valid = 1'b1;
            wdata = 8'h70 + 8'(b);
            @(posedge clk);
            #1;
        end
        wdata = 8'h72;
        @(negedge clk);
        checkOutput("mid_pre_write", 32'(mem_write), 32'd1);
        checkOutput("mid_pre_addr", 32'(mem_addr), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_write", 32'(mem_write), 32'd0);
        checkOutput("mid_rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("mid_rst_wdata_ready", 32'(wdata_ready), 32'd0);
`ifdef MEM_INITIATOR_STATS_EN
        checkOutput("mid_rst_wr_beats", 32'(wr_beats), 32'd0);
`endif
        wdata_valid = 1'b0;
        wdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        doWrite(5'd0, 3'd1, 64'h5B5A, 1'b0);
        doRead(5'd0, 3'd1, 64'h5B5A, 4'b1111);
`ifdef MEM_INITIATOR_STATS_EN
        @(negedge clk);
        checkOutput("stats_wr_beats", 32'(wr_beats), 32'd2);
        checkOutput("stats_rd_beats", 32'(rd_beats), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
